// File: rtl/load_pkg.sv
// Shared types, funct3 encodings and fault-classification helpers for the load path.
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    // funct3 codes that do not name a load this unit implements
    function automatic logic is_unsupported(input logic [2:0] f3);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // Halfwords need even addresses, words need 4-byte alignment
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic mis;
        case (f3)
            F3_LH, F3_LHU: mis = a[0];
            F3_LW:         mis = (a != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte/halfword/word selection with sign or zero extension.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    output logic [31:0] data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Pick the addressed lane and extend it according to the load type
    always_comb begin
        byte_s = word[{addr, 3'b000} +: 8];
        half_s = word[{addr[1], 4'b0000} +: 16];
        data   = '0;
        case (funct3)
            F3_LB:   data = 32'(byte_s);
            F3_LH:   data = 32'(half_s);
            F3_LW:   data = word;
            F3_LBU:  data = {24'd0, byte_s};
            F3_LHU:  data = {16'd0, half_s};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: issues word-aligned reads, waits for the response (with optional
// timeout), and returns the extended result to writeback as a one-cycle pulse.
module load_unit
    import load_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic        ld_done,
    output logic [31:0] ld_data,
    output logic        ld_fault,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    // A zero timeout still needs a legal (unused) one-bit counter
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       addr_r;
    logic [2:0]        f3_r;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              req_fault;
    logic              timeout_hit;
    logic [31:0]       ext_data;

    assign req_fault    = is_unsupported(funct3) | is_misaligned(funct3, ld_addr[1:0]);
    assign cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    // Fires on the WAIT cycle that would complete the allowed number of waits
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_VAL);
    assign mem_req_addr = {addr_r[31:2], 2'b00};

    load_extract u_extract (
        .word   (mem_resp_data),
        .funct3 (f3_r),
        .addr   (addr_r[1:0]),
        .data   (ext_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a response beats a simultaneous timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ld_valid) state_nxt = req_fault ? DONE : REQ;
            REQ:  if (mem_req_ready) state_nxt = WAIT;
            WAIT: if (mem_resp_valid || timeout_hit) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs; the request drops as soon as reset is raised
    always_comb begin
        stall         = ((state == IDLE) && ld_valid) || (state == REQ) || (state == WAIT);
        ld_done       = (state == DONE);
        mem_req_valid = (state == REQ) && !rst;
    end

    // Captured request, wait counter and the result held until the next DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= '0;
            f3_r     <= '0;
            cnt      <= '0;
            ld_data  <= '0;
            ld_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        addr_r <= ld_addr;
                        f3_r   <= funct3;
                        if (req_fault) begin
                            ld_data  <= '0;
                            ld_fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt_inc;
                    if (mem_resp_valid) begin
                        ld_data  <= ext_data;
                        ld_fault <= 1'b0;
                    end else if (timeout_hit) begin
                        ld_data  <= '0;
                        ld_fault <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: a driver issues loads and queues the expected
// result, a memory model answers with chosen delays, a monitor checks each ld_done.
module tb_load_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [2:0]  funct3;
    logic        stall;
    logic        ld_done;
    logic [31:0] ld_data;
    logic        ld_fault;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    load_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_valid       (ld_valid),
        .ld_addr        (ld_addr),
        .funct3         (funct3),
        .stall          (stall),
        .ld_done        (ld_done),
        .ld_data        (ld_data),
        .ld_fault       (ld_fault),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          lat;
    } exp_t;

    typedef struct {
        int          rdy;
        int          rsp;
        logic [31:0] addr;
        logic [31:0] word;
    } cfg_t;

    exp_t exp_q[$];
    cfg_t cfg_q[$];
    int   cyc = 0;
    int   issue_cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   req_cnt = 0;
    bit   mem_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: what a RISC-V load returns for this address/type/word
    task automatic ref_load(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] word,
                            output logic [31:0] data, output logic fault);
        int v;
        int sh;
        sh = int'(addr % 4);
        fault = (f3 == 3) || (f3 == 6) || (f3 == 7) ||
                (((f3 == 1) || (f3 == 5)) && (addr % 2 != 0)) ||
                ((f3 == 2) && (addr % 4 != 0));
        v = 0;
        case (f3)
            3'd0, 3'd4: begin
                v = int'((word >> (8 * sh)) & 32'hFF);
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = int'((word >> (16 * (sh / 2))) & 32'hFFFF);
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            3'd2: v = int'(word);
            default: v = 0;
        endcase
        data = fault ? 32'd0 : 32'(v);
    endtask

    // Queue the expectation, program the memory and raise ld_valid (at posedge+2)
    task automatic start_ld(input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] word, input int rdy, input int rsp);
        exp_t e;
        cfg_t c;
        ref_load(addr, f3, word, e.data, e.fault);
        if (e.fault) begin
            e.lat = 1;
        end else begin
            c.rdy = rdy; c.rsp = rsp; c.addr = {addr[31:2], 2'b00}; c.word = word;
            cfg_q.push_back(c);
            if (rsp > TO - 1) begin
                e.data = 32'd0; e.fault = 1'b1; e.lat = 3 + rdy + (TO - 1);
            end else begin
                e.lat = 3 + rdy + rsp;
            end
        end
        exp_q.push_back(e);
        ld_valid  = 1'b1;
        ld_addr   = addr;
        funct3    = f3;
        issue_cyc = cyc;
        #1 chk("stall_issue", {31'd0, stall}, 32'd1);
    endtask

    task automatic run_ld(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] word, input int rdy, input int rsp);
        int  r0;
        int  k;
        bit  got;
        logic [31:0] d;
        logic f;
        r0 = req_cnt;
        ref_load(addr, f3, word, d, f);
        start_ld(addr, f3, word, rdy, rsp);
        got = 1'b0;
        k = 0;
        while (k < 60) begin
            @(posedge clk); #2;
            k++;
            if (ld_done) begin
                got = 1'b1;
                break;
            end
            chk("stall_busy", {31'd0, stall}, 32'd1);
        end
        if (!got) begin
            chk("done_timeout", {31'd0, ld_done}, 32'd1);
        end else begin
            chk("stall_done", {31'd0, stall}, 32'd0);
        end
        ld_valid = 1'b0;
        if (f) chk("no_req_on_fault", 32'(req_cnt - r0), 32'd0);
        k = 0;
        while (mem_busy && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        @(posedge clk); #2;
    endtask

    // Monitor: every ld_done must match the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_valid) req_cnt = req_cnt + 1;
            if (ld_done) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", {31'd0, ld_done}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ld_data", ld_data, e.data);
                    chk("ld_fault", {31'd0, ld_fault}, {31'd0, e.fault});
                    chk("latency", 32'(cyc - issue_cyc), 32'(e.lat));
                end
            end
        end
    end

    // Memory model: ready after cfg.rdy cycles, response cfg.rsp cycles into WAIT
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        forever begin
            @(posedge clk); #2;
            if (mem_req_valid) begin
                cfg_t c;
                mem_busy = 1'b1;
                if (cfg_q.size() == 0) begin
                    chk("unexpected_req", {31'd0, mem_req_valid}, 32'd0);
                end else begin
                    c = cfg_q.pop_front();
                    chk("req_addr", mem_req_addr, c.addr);
                    for (int i = 0; i < c.rdy; i++) begin
                        mem_req_ready = 1'b0;
                        @(posedge clk); #2;
                        chk("req_held", {31'd0, mem_req_valid}, 32'd1);
                        chk("req_addr_stable", mem_req_addr, c.addr);
                    end
                    mem_req_ready = 1'b1;
                    @(posedge clk); #2;
                    mem_req_ready = 1'b0;
                    for (int i = 0; i < c.rsp; i++) begin
                        @(posedge clk); #2;
                    end
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = c.word;
                    @(posedge clk); #2;
                    mem_resp_valid = 1'b0;
                    mem_resp_data  = $urandom;
                end
                mem_busy = 1'b0;
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1; ld_valid = 1'b0; ld_addr = 32'd0; funct3 = 3'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, ld_done}, 32'd0);
        chk("rst_data", ld_data, 32'd0);
        chk("rst_fault", {31'd0, ld_fault}, 32'd0);
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        ld_valid = 1'b1;
        #1 chk("rst_stall_follows", {31'd0, stall}, 32'd1);
        ld_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;

        // Directed cases
        run_ld(32'h0000_0103, 3'd0, 32'h80FF_1234, 0, 0);  // lb  -> FFFFFF80
        run_ld(32'h0000_0202, 3'd5, 32'h8001_7FFF, 0, 0);  // lhu -> 00008001
        run_ld(32'h0000_0202, 3'd1, 32'h8001_7FFF, 0, 0);  // lh  -> FFFF8001
        run_ld(32'h0000_0301, 3'd2, 32'hCAFE_F00D, 0, 0);  // misaligned lw
        run_ld(32'h0000_0400, 3'd2, 32'h1357_9BDF, 3, 0);  // ready held low 3 cycles
        run_ld(32'h0000_0604, 3'd3, 32'h1111_1111, 0, 0);  // unsupported funct3
        run_ld(32'h0000_0508, 3'd2, 32'h2468_ACE0, 0, TO - 1);  // response on last allowed cycle
        run_ld(32'h0000_0600, 3'd2, 32'h5555_AAAA, 0, 6);  // timeout, late response
        chk("fault_held", {31'd0, ld_fault}, 32'd1);
        chk("data_held", ld_data, 32'd0);

        // Reset while waiting for the response
        cfg_q.push_back('{0, 6, 32'h0000_0700, 32'hDEAD_BEEF});
        ld_valid = 1'b1; ld_addr = 32'h0000_0700; funct3 = 3'd2;
        run_ld_pre: begin
            @(posedge clk); #2;
            @(posedge clk); #2;
        end
        chk("in_wait_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1; ld_valid = 1'b0;
        #1 chk("rst_drops_req", {31'd0, mem_req_valid}, 32'd0);
        @(posedge clk); #2;
        chk("wrst_stall", {31'd0, stall}, 32'd0);
        chk("wrst_done", {31'd0, ld_done}, 32'd0);
        chk("wrst_data", ld_data, 32'd0);
        chk("wrst_fault", {31'd0, ld_fault}, 32'd0);
        chk("wrst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("wrst_req_addr", mem_req_addr, 32'd0);
        rst = 1'b0;
        k = 0;
        while (mem_busy && k < 40) begin
            @(posedge clk); #2;
            k++;
        end
        @(posedge clk); #2;
        run_ld(32'h0000_0000, 3'd4, 32'h1234_56A5, 0, 0);  // lbu -> 000000A5

        // Randomized loads
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [2:0]  f;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            f = 3'($urandom_range(0, 7));
            run_ld(a, f, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));
        end

        repeat (4) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_unit.md
# load_unit

Load-side counterpart of the execute/memory stage's store path: it issues word-aligned data-memory reads over a valid/ready request channel, waits for the response, then extracts and sign- or zero-extends the addressed byte, halfword or word per RISC-V `funct3`. It stalls the pipeline while a load is in flight. It delivers a one-cycle `ld_done` pulse with the result to writeback. Misaligned or unsupported loads fault without touching memory.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in WAIT before faulting; 0 disables the timeout.
- `clk` in 1: clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld_valid` in 1: pipeline requests a load; held high while `stall` is high.
- `ld_addr` in 32: byte address, the ALU result.
- `funct3` in 3: load type. 0 = lb, 1 = lh, 2 = lw, 4 = lbu, 5 = lhu.
- `stall` out 1: pipeline must hold.
- `ld_done` out 1: one-cycle pulse; `ld_data`/`ld_fault` are valid this cycle.
- `ld_data` out 32: extended load result.
- `ld_fault` out 1: misaligned, unsupported `funct3`, or timeout.
- `mem_req_valid` out 1: read request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out 32: `{addr[31:2], 2'b00}`.
- `mem_resp_valid` in 1: read data valid.
- `mem_resp_data` in 32: word read from memory.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - If `ld_valid`, register `ld_addr` and `funct3`.
  - Fault check: `funct3` ∈ {3, 6, 7}; or lh/lhu with `addr[0]` = 1; or lw with `addr[1:0]` ≠ 0.
  - Fault detected: go to DONE with the fault latched. No memory request is made.
  - No fault: go to REQ.
- **REQ**
  - `mem_req_valid` = 1; `mem_req_addr` comes from the registered address.
  - On `mem_req_ready`, go to WAIT.
  - `mem_resp_valid` is ignored in REQ.
- **WAIT**
  - Counter increments each cycle.
  - On `mem_resp_valid`, register the extracted data and go to DONE.
  - If `TIMEOUT_CYCLES` ≠ 0 and the counter reaches `TIMEOUT_CYCLES` without a response, latch the fault and go to DONE.
  - A response and the timeout in the same cycle: the response wins.
- **DONE**
  - `ld_done` = 1 for exactly one cycle, then go to IDLE.
  - `ld_valid` is ignored in DONE.
- Extraction, selected by registered `addr[1:0]`:
  - lb / lbu: byte `data[8*a+7 : 8*a]`, sign- / zero-extended.
  - lh / lhu: half `data[16*a[1]+15 : 16*a[1]]`, sign- / zero-extended.
  - lw: the whole word.
- Fault result: `ld_data` = 0, `ld_fault` = 1.
- `stall` = (IDLE & `ld_valid`) | REQ | WAIT. It is combinational and low in DONE.
- Late responses are not tracked: a response arriving after a timeout, or a `mem_resp_valid` outside WAIT, is dropped.

## Timing
- Reset values: state IDLE; `stall` follows `ld_valid` combinationally; `ld_done` 0; `ld_data` 0; `ld_fault` 0; `mem_req_valid` 0; `mem_req_addr` 0; counter 0.
- `ld_data` and `ld_fault` hold their values until the next DONE.
- Latency with an always-ready memory and a 1-cycle response:
  - `ld_valid` at cycle 0, request at cycle 1, response at cycle 2, `ld_done` at cycle 3.
  - Each extra cycle of not-ready or response delay adds one cycle.
- Fault path: `ld_valid` at cycle 0, `ld_done` at cycle 1.
- `mem_req_valid` stays asserted until the ready handshake. `mem_req_addr` is stable while valid.
- The counter clears on entry to WAIT. It is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates.
- `rst` in any state returns to IDLE on the next edge and drops `mem_req_valid` immediately. An outstanding response after reset is ignored.

## Structure
- `load_pkg`:
  - state enum (IDLE/REQ/WAIT/DONE);
  - `funct3` constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`;
  - function `is_misaligned(funct3, addr[1:0])`.
- Sub-module `load_extract`: combinational. Inputs are `word`, `funct3`, `addr[1:0]`; output is the 32-bit extended data. It is instantiated once in `load_unit`.

## Test plan
- lb at `0x103`, memory word `0x80FF_1234`, 1-cycle memory:
  - `mem_req_addr` = `0x100`;
  - `ld_data` = `0xFFFF_FF80` with `ld_done` at cycle 3;
  - `stall` high in cycles 0–2.
- lhu at `0x202` and lh at `0x202`, word `0x8001_7FFF`: `ld_data` = `0x0000_8001` and `0xFFFF_8001` respectively.
- lw at `0x301`:
  - `mem_req_valid` never asserts;
  - `ld_done` at cycle 1 with `ld_fault` = 1 and `ld_data` = 0.
- lw at `0x400` with `mem_req_ready` low for 3 cycles:
  - request and address held stable;
  - `ld_done` at cycle 6 with the correct word.
- `TIMEOUT_CYCLES` = 4, no response:
  - `ld_fault` = 1 after 4 WAIT cycles;
  - a later `mem_resp_valid` is ignored.
- `rst` asserted in WAIT: next cycle state is IDLE, all outputs at reset values; a subsequent lbu at `0x0` works normally.
